serial_deframer: RTL

Parametrised serial-to-parallel deframer. Shifts a LANES-bit-wide serial stream into an NDATA-bit word, with selectable bit order and a start-of-frame resync. Presents each completed word on a valid/ready output register. Sits between the line receiver and the word-level consumers, as the next generation of the single-lane serial buffer.

---
 rtl/serial_deframer_pkg.sv | 28 ++
 rtl/serial_deframer_if.sv | 33 +++
 rtl/serial_deframer_lane_shift_reg.sv | 43 ++++
 rtl/serial_deframer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/serial_deframer_pkg.sv
// Shared types and elaboration helpers for the serial deframer slice.
// Beat/counter sizing functions are evaluated at elaboration only.
// Holds the output-register state encoding used by the top module.
package deframer_pkg;

   // Output register occupancy: empty, or holding a word not yet taken.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Number of valid beats that make up one word.
   function automatic int beats(input int ndata, input int lanes);
      return ndata / lanes;
   endfunction

   // Width of the beat counter; never narrower than one bit.
   function automatic int cnt_width(input int nbeat);
      return (nbeat <= 1) ? 1 : $clog2(nbeat);
   endfunction

   // Legal geometry: supported lane count and a whole number of beats per word.
   function automatic bit cfg_valid(input int ndata, input int lanes);
      return (lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8) &&
             (ndata >= lanes) && ((ndata % lanes) == 0);
   endfunction

endpackage

// File: rtl/serial_deframer_if.sv
// Beat-in / word-out bundle between the line receiver, deframer and consumer.
// Carries no logic; widths follow NDATA/LANES.
// slave = deframer side, master = the side feeding beats and taking words.
interface serial_deframer_if
#(
   parameter int NDATA = 128,
   parameter int LANES = 1
) ();
   import deframer_pkg::*;

   localparam int NBEAT = beats(NDATA, LANES);
   localparam int CW    = cnt_width(NBEAT);

   logic [LANES-1:0] din;
   logic             din_valid;
   logic             sof;
   logic [NDATA-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             overrun;
   logic [CW-1:0]    beat_cnt;

   modport slave (
      input  din, din_valid, sof, dout_ready,
      output dout, dout_valid, overrun, beat_cnt
   );

   modport master (
      output din, din_valid, sof, dout_ready,
      input  dout, dout_valid, overrun, beat_cnt
   );

endinterface

// File: rtl/serial_deframer_lane_shift_reg.sv
// Directional multi-lane shift register; shifts LANES bits in per enabled edge.
// dout is the post-shift value (what the register holds after the next ena edge).
// No backpressure: shifts whenever ena is high.
module lane_shift_reg
#(
   parameter int WIDTH     = 128,
   parameter int LANES     = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [LANES-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_shifted;

   // Shift direction picks where the newest beat lands in the word.
   generate
      if (WIDTH == LANES) begin : g_single
         assign w_shifted = din;
      end else if (MSB_FIRST) begin : g_msb
         assign w_shifted = {r_sr[WIDTH-LANES-1:0], din};
      end else begin : g_lsb
         assign w_shifted = {din, r_sr[WIDTH-1:LANES]};
      end
   endgenerate

   // Accumulate on every qualified beat; reset clears history.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr <= '0;
      end else if (ena) begin
         r_sr <= w_shifted;
      end
   end

   // Exposing the shifted value lets the completing beat join its word with no extra cycle.
   assign dout = w_shifted;

endmodule

// File: rtl/serial_deframer.sv
// Serial-to-parallel deframer: LANES-bit beats into NDATA-bit words, sof resync.
// Latency: word visible the cycle after its completing beat is sampled.
// Backpressure: one-word output register; a word completing while it is held and not taken is dropped with an overrun pulse.
module serial_deframer
   import deframer_pkg::*;
#(
   parameter int NDATA     = 128,
   parameter int LANES     = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   serial_deframer_if.slave bus
);

   localparam int NBEAT = beats(NDATA, LANES);
   localparam int CW    = cnt_width(NBEAT);
   localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);
   localparam logic [CW-1:0] SOF_NEXT  = (NBEAT == 1) ? '0 : CW'(1);
   localparam bit            SOF_DONE  = (NBEAT == 1);

   generate
      if (!cfg_valid(NDATA, LANES)) begin : g_bad_cfg
         $error("serial_deframer: NDATA must be a multiple of LANES and LANES in {1,2,4,8}");
      end
   endgenerate

   logic [NDATA-1:0] w_word;
   logic             w_complete;
   logic [CW-1:0]    w_beat_cnt_nxt;
   logic [CW-1:0]    r_beat_cnt;
   logic             w_load;
   logic             w_drop;
   logic [NDATA-1:0] r_dout;
   logic             r_overrun;
   out_state_t       r_state;
   out_state_t       w_state_nxt;

   lane_shift_reg #(
      .WIDTH     (NDATA),
      .LANES     (LANES),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk  (clk),
      .rst  (rst),
      .ena  (bus.din_valid),
      .din  (bus.din),
      .dout (w_word)
   );

   // Beat counting and word completion; sof restarts the word at this beat.
   always_comb begin
      w_complete     = 1'b0;
      w_beat_cnt_nxt = r_beat_cnt;
      if (bus.din_valid) begin
         if (bus.sof) begin
            w_complete     = SOF_DONE;
            w_beat_cnt_nxt = SOF_NEXT;
         end else if (r_beat_cnt == LAST_BEAT) begin
            w_complete     = 1'b1;
            w_beat_cnt_nxt = '0;
         end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
         end
      end
   end

   // Output register occupancy: load when free or being drained, otherwise drop.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         OUT_EMPTY: begin
            if (w_complete) begin
               w_load      = 1'b1;
               w_state_nxt = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (w_complete) begin
               if (bus.dout_ready) begin
                  w_load = 1'b1;
               end else begin
                  w_drop = 1'b1;
               end
            end else if (bus.dout_ready) begin
               w_state_nxt = OUT_EMPTY;
            end
         end
         default: w_state_nxt = OUT_EMPTY;
      endcase
   end

   // Output state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= OUT_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Beat counter, held word and overrun pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= '0;
         r_dout     <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_beat_cnt <= w_beat_cnt_nxt;
         r_overrun  <= w_drop;
         if (w_load) begin
            r_dout <= w_word;
         end
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = (r_state == OUT_FULL);
   assign bus.overrun    = r_overrun;
   assign bus.beat_cnt   = r_beat_cnt;

endmodule
